// File: rtl/nmi_scheduler.sv
// NMI arbiter for the magic, DivMMC and pause buttons: latches requests, grants one per frame,
// drives /NMI until the 0x0066 fetch, follows the handler to RETN, then holds off for a cooldown.
module nmi_scheduler #(
   parameter int          COOLDOWN_FRAMES = 2,
   parameter int          TIMEOUT_FRAMES  = 3,
   parameter logic [7:0]  CAUSE_PORT      = 8'h10
) (
   input  logic        clk28,
   input  logic        rst,
   input  logic        bus_mreq,
   input  logic        bus_ioreq,
   input  logic        bus_m1,
   input  logic        bus_rd,
   input  logic [15:0] bus_a,
   input  logic [7:0]  bus_d,
   input  logic        n_int,
   input  logic        n_int_next,
   input  logic        magic_req,
   input  logic        div_req,
   input  logic        pause_req,
   input  logic        nmi_en,
   output logic        n_nmi,
   output logic        nmi_active,
   output logic [1:0]  nmi_src,
   output logic [7:0]  d_out,
   output logic        d_out_active
);

   localparam int MAX_FRAMES = (COOLDOWN_FRAMES > TIMEOUT_FRAMES) ? COOLDOWN_FRAMES : TIMEOUT_FRAMES;
   localparam int CW = (MAX_FRAMES < 1) ? 1 : $clog2(MAX_FRAMES + 1);
   localparam logic [CW-1:0] TIMEOUT_LD  = CW'(TIMEOUT_FRAMES);
   localparam logic [CW-1:0] COOLDOWN_LD = CW'(COOLDOWN_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_SERVICE,
      ST_COOLDOWN
   } state_t;

   state_t        state_q;
   logic          n_nmi_q;
   logic [1:0]    nmi_src_q;
   logic [2:0]    pending_q;
   logic [2:0]    pending_d;
   logic [2:0]    req_q;
   logic [CW-1:0] cnt_q;
   logic          timeout_q;
   logic          ed_seen_q;
   logic [7:0]    opcode_q;
   logic          m1_rd_q;
   logic          doa_q;
   logic          doa_prev_q;

   logic [2:0]    req_in;
   logic [2:0]    req_rise;
   logic          frame_tick;
   logic          m1_rd;
   logic          nmi_fetch;
   logic          m1_fall;
   logic          cs;
   logic          grant_ok;
   logic [2:0]    grant_mask;
   logic [1:0]    grant_src;
   logic [2:0]    pending_clr;
   logic [CW-1:0] cnt_dec;
   logic          retn_done;
   logic          timeout_hit;
   logic          doa_fall;

   assign req_in      = {pause_req, div_req, magic_req};
   assign req_rise    = req_in & ~req_q;
   assign frame_tick  = n_int & ~n_int_next;
   assign m1_rd       = bus_mreq & bus_m1 & bus_rd;
   assign nmi_fetch   = m1_rd && (bus_a == 16'h0066);
   assign m1_fall     = m1_rd_q & ~m1_rd;
   assign cs          = bus_ioreq && bus_rd && (bus_a == {CAUSE_PORT, 8'hFF});
   assign grant_ok    = (state_q == ST_IDLE) && frame_tick && nmi_en && (pending_q != 3'b000);
   assign pending_clr = grant_ok ? grant_mask : 3'b000;
   assign cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
   assign retn_done   = (state_q == ST_SERVICE) && m1_fall && ed_seen_q && (opcode_q == 8'h45);
   // A 0x0066 fetch on the final tick takes the handler path, never the timeout.
   assign timeout_hit = (state_q == ST_ASSERT) && !nmi_fetch && frame_tick && (cnt_dec == '0);
   assign doa_fall    = doa_prev_q & ~doa_q;

   always_comb begin
      grant_mask = 3'b000;
      grant_src  = 2'd0;
      if (pending_q[0]) begin
         grant_mask = 3'b001;
         grant_src  = 2'd1;
      end else if (pending_q[1]) begin
         grant_mask = 3'b010;
         grant_src  = 2'd2;
      end else if (pending_q[2]) begin
         grant_mask = 3'b100;
         grant_src  = 2'd3;
      end
   end

   // Set beats clear; a disabled scheduler drops everything.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_pending
         assign pending_d[gi] = nmi_en & (req_rise[gi] | (pending_q[gi] & ~pending_clr[gi]));
      end
   endgenerate

   always_ff @(posedge clk28) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         n_nmi_q    <= 1'b1;
         nmi_src_q  <= 2'd0;
         pending_q  <= 3'b000;
         req_q      <= 3'b000;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         ed_seen_q  <= 1'b0;
         opcode_q   <= 8'h00;
         m1_rd_q    <= 1'b0;
         doa_q      <= 1'b0;
         doa_prev_q <= 1'b0;
      end else begin
         req_q      <= req_in;
         pending_q  <= pending_d;
         m1_rd_q    <= m1_rd;
         doa_q      <= cs;
         doa_prev_q <= doa_q;
         if (m1_rd) begin
            opcode_q <= bus_d;
         end
         if (timeout_hit) begin
            timeout_q <= 1'b1;
         end else if (doa_fall) begin
            timeout_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (grant_ok) begin
                  nmi_src_q <= grant_src;
                  cnt_q     <= TIMEOUT_LD;
                  n_nmi_q   <= 1'b0;
                  state_q   <= ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               if (nmi_fetch) begin
                  n_nmi_q   <= 1'b1;
                  ed_seen_q <= 1'b0;
                  state_q   <= ST_SERVICE;
               end else if (frame_tick) begin
                  cnt_q <= cnt_dec;
                  if (cnt_dec == '0) begin
                     n_nmi_q <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_SERVICE: begin
               if (m1_fall) begin
                  ed_seen_q <= (opcode_q == 8'hED);
               end
               if (retn_done) begin
                  cnt_q   <= COOLDOWN_LD;
                  state_q <= (COOLDOWN_FRAMES == 0) ? ST_IDLE : ST_COOLDOWN;
               end
            end
            ST_COOLDOWN: begin
               if (frame_tick) begin
                  cnt_q <= cnt_dec;
                  if (cnt_dec == '0) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign n_nmi        = n_nmi_q;
   assign nmi_active   = (state_q == ST_ASSERT) || (state_q == ST_SERVICE);
   assign nmi_src      = nmi_src_q;
   assign d_out_active = doa_q;
   assign d_out        = {timeout_q, nmi_active, nmi_src_q, 1'b0, pending_q};

endmodule

// File: tb/tb_nmi_scheduler.sv
// Bench for nmi_scheduler: directed button/bus sequences, status-port reads checked through a scoreboard.
module tb_nmi_scheduler;

   logic        clk28 = 1'b0;
   logic        rst = 1'b1;
   logic        bus_mreq = 1'b0;
   logic        bus_ioreq = 1'b0;
   logic        bus_m1 = 1'b0;
   logic        bus_rd = 1'b0;
   logic [15:0] bus_a = 16'h0000;
   logic [7:0]  bus_d = 8'h00;
   logic        n_int = 1'b1;
   logic        n_int_next = 1'b1;
   logic        magic_req = 1'b0;
   logic        div_req = 1'b0;
   logic        pause_req = 1'b0;
   logic        nmi_en = 1'b1;
   logic        n_nmi;
   logic        nmi_active;
   logic [1:0]  nmi_src;
   logic [7:0]  d_out;
   logic        d_out_active;

   int checks_passed = 0;
   int checks_total  = 0;
   logic [7:0] exp_q[$];

   nmi_scheduler #(
      .COOLDOWN_FRAMES(2),
      .TIMEOUT_FRAMES (3),
      .CAUSE_PORT     (8'h10)
   ) dut (
      .clk28       (clk28),
      .rst         (rst),
      .bus_mreq    (bus_mreq),
      .bus_ioreq   (bus_ioreq),
      .bus_m1      (bus_m1),
      .bus_rd      (bus_rd),
      .bus_a       (bus_a),
      .bus_d       (bus_d),
      .n_int       (n_int),
      .n_int_next  (n_int_next),
      .magic_req   (magic_req),
      .div_req     (div_req),
      .pause_req   (pause_req),
      .nmi_en      (nmi_en),
      .n_nmi       (n_nmi),
      .nmi_active  (nmi_active),
      .nmi_src     (nmi_src),
      .d_out       (d_out),
      .d_out_active(d_out_active)
   );

   always #5 clk28 = ~clk28;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks_total++;
      if (obs === exp) begin
         checks_passed++;
         $display("ok   %s obs=%02h", tag, obs);
      end else begin
         $display("FAIL %s obs=%02h exp=%02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk28);
      #1;
   endtask

   task automatic frame();
      n_int_next = 1'b0;
      tick();
      n_int_next = 1'b1;
   endtask

   task automatic fetch(input logic [15:0] a, input logic [7:0] d);
      bus_mreq = 1'b1; bus_m1 = 1'b1; bus_rd = 1'b1; bus_a = a; bus_d = d;
      tick();
      bus_mreq = 1'b0; bus_m1 = 1'b0; bus_rd = 1'b0; bus_a = 16'h0000; bus_d = 8'h00;
      tick();
   endtask

   // m = {pause, div, magic}
   task automatic press(input logic [2:0] m);
      {pause_req, div_req, magic_req} = m;
      tick();
      tick();
      {pause_req, div_req, magic_req} = 3'b000;
      tick();
   endtask

   task automatic read_status(input string tag, input logic [7:0] exp);
      bit got;
      logic [7:0] e;
      got = 1'b0;
      exp_q.push_back(exp);
      bus_ioreq = 1'b1; bus_rd = 1'b1; bus_a = 16'h10FF;
      #1;
      check({tag, "_doa_early"}, {7'd0, d_out_active}, 8'h00);
      tick();
      bus_ioreq = 1'b0; bus_rd = 1'b0; bus_a = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         if (d_out_active) begin
            e = exp_q.pop_front();
            check(tag, d_out, e);
            got = 1'b1;
            break;
         end
         tick();
      end
      if (!got) begin
         void'(exp_q.pop_front());
         check({tag, "_no_doa"}, 8'h00, 8'h01);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      tick(); tick();
      check("rst_n_nmi", {7'd0, n_nmi}, 8'h01);
      check("rst_active", {7'd0, nmi_active}, 8'h00);
      check("rst_src", {6'd0, nmi_src}, 8'h00);
      check("rst_doa", {7'd0, d_out_active}, 8'h00);
      rst = 1'b0;
      tick();
      read_status("rst_status", 8'h00);

      // Magic: grant, 0x0066, ED 45, cooldown
      press(3'b001);
      read_status("magic_pending", 8'h01);
      frame();
      check("magic_n_nmi", {7'd0, n_nmi}, 8'h00);
      check("magic_src", {6'd0, nmi_src}, 8'h01);
      read_status("magic_assert", 8'h50);
      fetch(16'h0066, 8'h00);
      check("magic_release", {7'd0, n_nmi}, 8'h01);
      check("magic_service", {7'd0, nmi_active}, 8'h01);
      fetch(16'h1000, 8'hED);
      fetch(16'h1001, 8'h45);
      check("magic_retn", {7'd0, nmi_active}, 8'h00);
      frame(); frame();

      // Div and pause together: div first, ED 00 45 does not exit
      press(3'b110);
      read_status("dp_pending", 8'h16);
      frame();
      check("div_src", {6'd0, nmi_src}, 8'h02);
      check("div_n_nmi", {7'd0, n_nmi}, 8'h00);
      read_status("div_assert", 8'h64);
      fetch(16'h0066, 8'h00);
      fetch(16'h2000, 8'hED);
      fetch(16'h2001, 8'h00);
      fetch(16'h2002, 8'h45);
      check("ed00_45_stay", {7'd0, nmi_active}, 8'h01);
      fetch(16'h2003, 8'hED);
      fetch(16'h2004, 8'h45);
      check("div_retn", {7'd0, nmi_active}, 8'h00);
      frame(); frame();
      check("cool_end_no_grant", {7'd0, n_nmi}, 8'h01);
      frame();
      check("pause_src", {6'd0, nmi_src}, 8'h03);
      check("pause_n_nmi", {7'd0, n_nmi}, 8'h00);

      // Pause never fetched: timeout after third tick
      frame(); frame();
      check("to_still_low", {7'd0, n_nmi}, 8'h00);
      frame();
      check("to_release", {7'd0, n_nmi}, 8'h01);
      check("to_inactive", {7'd0, nmi_active}, 8'h00);
      read_status("to_status", 8'hB0);
      tick(); tick();
      read_status("to_cleared", 8'h30);

      // Disabled: presses ignored
      nmi_en = 1'b0;
      press(3'b111);
      frame();
      check("dis_no_grant", {7'd0, n_nmi}, 8'h01);
      read_status("dis_status", 8'h30);
      nmi_en = 1'b1;
      tick();

      // Reset while asserting
      press(3'b001);
      frame();
      check("pre_rst_n_nmi", {7'd0, n_nmi}, 8'h00);
      rst = 1'b1;
      tick();
      check("mid_rst_n_nmi", {7'd0, n_nmi}, 8'h01);
      check("mid_rst_active", {7'd0, nmi_active}, 8'h00);
      rst = 1'b0;
      tick();

      // Fetch on the final timeout tick wins
      press(3'b001);
      frame(); frame(); frame();
      bus_mreq = 1'b1; bus_m1 = 1'b1; bus_rd = 1'b1; bus_a = 16'h0066; bus_d = 8'h00;
      n_int_next = 1'b0;
      tick();
      n_int_next = 1'b1;
      bus_mreq = 1'b0; bus_m1 = 1'b0; bus_rd = 1'b0; bus_a = 16'h0000;
      check("coinc_n_nmi", {7'd0, n_nmi}, 8'h01);
      check("coinc_service", {7'd0, nmi_active}, 8'h01);
      tick();
      read_status("coinc_status", 8'h50);
      fetch(16'h3000, 8'hED);
      fetch(16'h3001, 8'h45);
      check("coinc_retn", {7'd0, nmi_active}, 8'h00);

      // Press during cooldown: grant only on the tick after cooldown ends
      press(3'b001);
      frame();
      check("cd_tick1", {7'd0, n_nmi}, 8'h01);
      frame();
      check("cd_end_no_grant", {7'd0, n_nmi}, 8'h01);
      frame();
      check("cd_grant", {7'd0, n_nmi}, 8'h00);
      check("cd_src", {6'd0, nmi_src}, 8'h01);
      read_status("cd_status", 8'h50);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
